// File: rtl/qubit_issue_arbiter_pkg.sv
// qsched_pkg: shared types and helpers for the qubit issue arbiter.
//   qw_of()      : index width for a count of n items (minimum 1 bit)
//   REC_QW/REC_SW: field widths of the issue record, sized for 4096 qubits / 8 slots
//   iss_state_e  : output-stage state (StEmpty, StHold)
//   issue_rec_t  : registered issue record {qa, qb, two_q, src}
package qsched_pkg;

    function automatic int unsigned qw_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Widen these if the arbiter is built for more qubits or more slots.
    localparam int unsigned REC_QW = qw_of(4096);
    localparam int unsigned REC_SW = qw_of(8);

    typedef enum logic {
        StEmpty = 1'b0,
        StHold  = 1'b1
    } iss_state_e;

    typedef struct packed {
        logic [REC_QW-1:0] qa;
        logic [REC_QW-1:0] qb;
        logic              two_q;
        logic [REC_SW-1:0] src;
    } issue_rec_t;

endpackage

// File: rtl/qubit_issue_arbiter_if.sv
// qubit_issue_arbiter_if: request, issue and completion bundle of the qubit issue arbiter.
//   req_*  : per-slot requests (valid, qa, qb, two_q) and one-hot combinational grant
//   iss_*  : issue record towards the pulse back-end with valid/ready handshake
//   cmp_*  : completion that releases qubit locks
//   master : requester / back-end side, slave : arbiter side
interface qubit_issue_arbiter_if #(
    parameter int unsigned NUM_REQ    = 8,
    parameter int unsigned NUM_QUBITS = 4096
);
    import qsched_pkg::*;

    localparam int unsigned QW = qw_of(NUM_QUBITS);
    localparam int unsigned SW = qw_of(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_gnt;
    logic [NUM_REQ-1:0][QW-1:0] req_qa;
    logic [NUM_REQ-1:0][QW-1:0] req_qb;
    logic [NUM_REQ-1:0]         req_two_q;

    logic          iss_valid;
    logic          iss_ready;
    logic [QW-1:0] iss_qa;
    logic [QW-1:0] iss_qb;
    logic          iss_two_q;
    logic [SW-1:0] iss_src;

    logic          cmp_valid;
    logic [QW-1:0] cmp_qa;
    logic [QW-1:0] cmp_qb;
    logic          cmp_two_q;

    modport master (
        output req_valid, req_qa, req_qb, req_two_q, iss_ready,
               cmp_valid, cmp_qa, cmp_qb, cmp_two_q,
        input  req_gnt, iss_valid, iss_qa, iss_qb, iss_two_q, iss_src
    );

    modport slave (
        input  req_valid, req_qa, req_qb, req_two_q, iss_ready,
               cmp_valid, cmp_qa, cmp_qb, cmp_two_q,
        output req_gnt, iss_valid, iss_qa, iss_qb, iss_two_q, iss_src
    );

endinterface

// File: rtl/qubit_issue_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector
//   ptr : index of the highest-priority slot
//   gnt : one-hot grant to the first requester at or after ptr (wrapping)
module rr_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qubit_issue_arbiter.sv
// qubit_issue_arbiter: grants one instruction slot per cycle whose operand qubits are not locked,
// locks those qubits until a completion releases them, and presents the grant as a registered
// issue record with a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request / issue / completion bundle (slave side)
//   busy_cnt   : number of currently locked qubits
//   err        : sticky; set when a completion names a qubit that is not locked
//   stall_cnt  : only with QIA_STATS_EN; saturating count of cycles with requests but no grant
module qubit_issue_arbiter
    import qsched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 8,
    parameter int unsigned NUM_QUBITS = 4096,
    localparam int unsigned QW = qw_of(NUM_QUBITS),
    localparam int unsigned SW = qw_of(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qubit_issue_arbiter_if.slave bus,
    output logic [QW:0]          busy_cnt,
    output logic                 err
`ifdef QIA_STATS_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int unsigned CW = QW + 1;

    logic [NUM_QUBITS-1:0] busy_q, busy_d;
    logic [CW-1:0]         busy_cnt_q, busy_cnt_d;
    logic                  err_q, err_d;
    logic [SW-1:0]         ptr_q, ptr_d;
    iss_state_e            state_q, state_d;
    issue_rec_t            iss_q, iss_d;

    logic [NUM_REQ-1:0] eligible, rr_gnt, gnt;
    logic               can_grant, any_gnt;
    logic [SW-1:0]      gnt_idx;
    logic [QW-1:0]      g_qa, g_qb;
    logic               g_two;
    logic [1:0]         n_set, n_clr;

    // Eligibility looks only at registered locks, so a release is visible one cycle later.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] && !busy_q[bus.req_qa[i]] &&
                          (!bus.req_two_q[i] || !busy_q[bus.req_qb[i]]);
        end
    end

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .req(eligible),
        .ptr(ptr_q),
        .gnt(rr_gnt)
    );

    assign gnt         = (rst_n && can_grant) ? rr_gnt : '0;
    assign any_gnt     = |gnt;
    assign bus.req_gnt = gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = SW'(i);
        end
    end

    assign g_qa  = bus.req_qa[gnt_idx];
    assign g_qb  = bus.req_qb[gnt_idx];
    assign g_two = bus.req_two_q[gnt_idx];

    // Output-stage FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StEmpty;
        else        state_q <= state_d;
    end

    // Output-stage FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (any_gnt) state_d = StHold;
            StHold:  if (!any_gnt && bus.iss_ready) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Output-stage FSM: outputs.
    always_comb begin
        bus.iss_valid = (state_q == StHold);
        can_grant     = (state_q == StEmpty) || bus.iss_ready;
    end

    always_comb begin
        iss_d = iss_q;
        if (any_gnt) begin
            iss_d.qa    = REC_QW'(g_qa);
            iss_d.qb    = g_two ? REC_QW'(g_qb) : '0;
            iss_d.two_q = g_two;
            iss_d.src   = REC_SW'(gnt_idx);
        end
    end

    // Clears are judged against registered locks; a grant only ever locks free qubits, so the
    // set and clear masks can never touch the same bit in one cycle.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        n_set  = 2'd0;
        n_clr  = 2'd0;
        if (bus.cmp_valid) begin
            if (busy_q[bus.cmp_qa]) begin
                busy_d[bus.cmp_qa] = 1'b0;
                n_clr              = n_clr + 2'd1;
            end else begin
                err_d = 1'b1;
            end
            if (bus.cmp_two_q && (bus.cmp_qb != bus.cmp_qa)) begin
                if (busy_q[bus.cmp_qb]) begin
                    busy_d[bus.cmp_qb] = 1'b0;
                    n_clr              = n_clr + 2'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        if (any_gnt) begin
            busy_d[g_qa] = 1'b1;
            n_set        = 2'd1;
            if (g_two && (g_qb != g_qa)) begin
                busy_d[g_qb] = 1'b1;
                n_set        = 2'd2;
            end
        end
        busy_cnt_d = busy_cnt_q + CW'(n_set) - CW'(n_clr);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) ptr_d = (gnt_idx == SW'(NUM_REQ - 1)) ? '0 : gnt_idx + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            iss_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            iss_q      <= iss_d;
        end
    end

    assign bus.iss_qa    = iss_q.qa[QW-1:0];
    assign bus.iss_qb    = iss_q.qb[QW-1:0];
    assign bus.iss_two_q = iss_q.two_q;
    assign bus.iss_src   = iss_q.src[SW-1:0];
    assign busy_cnt      = busy_cnt_q;
    assign err           = err_q;

`ifdef QIA_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((|bus.req_valid) && !any_gnt && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_qubit_issue_arbiter.sv
// Directed bench for qubit_issue_arbiter: expected issue records are queued when a grant is
// expected and compared when the issue stage presents them.
module tb_qubit_issue_arbiter;

    typedef struct packed {
        logic [11:0] qa;
        logic [11:0] qb;
        logic        two_q;
        logic [2:0]  src;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic [12:0] busy_cnt;
    logic        err;
`ifdef QIA_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    rec_t sb[$];

    qubit_issue_arbiter_if #(.NUM_REQ(8), .NUM_QUBITS(4096)) bus ();

    qubit_issue_arbiter #(
        .NUM_REQ(8),
        .NUM_QUBITS(4096)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy_cnt(busy_cnt),
        .err(err)
`ifdef QIA_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [11:0] qa, input logic [11:0] qb,
                                input logic two_q, input logic [2:0] src);
        return {qa, qb, two_q, src};
    endfunction

    // Compare the presented issue record with the oldest expectation; it retires on handshake.
    task automatic issue_chk(input string tag);
        rec_t obs;
        chk({tag, ".valid"}, 32'(bus.iss_valid), 32'd1);
        obs = {bus.iss_qa, bus.iss_qb, bus.iss_two_q, bus.iss_src};
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s.sb: observed record 0x%0h, required none pending", tag, obs);
        end
        if (sb.size() != 0) begin
            chk({tag, ".rec"}, 32'(obs), 32'(sb[0]));
            if (bus.iss_ready) void'(sb.pop_front());
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".iss_valid"}, 32'(bus.iss_valid), 32'd0);
        chk({tag, ".busy_cnt"}, 32'(busy_cnt), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
        chk({tag, ".gnt"}, 32'(bus.req_gnt), 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_qa    = '0;
        bus.req_qb    = '0;
        bus.req_two_q = '0;
        bus.iss_ready = 1'b1;
        bus.cmp_valid = 1'b0;
        bus.cmp_qa    = '0;
        bus.cmp_qb    = '0;
        bus.cmp_two_q = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_qa[0]    = 12'h001;
        #2;
        // Reset state, with a request already pending.
        chk("rst.gnt", 32'(bus.req_gnt), 32'd0);
        chk("rst.iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("rst.busy_cnt", 32'(busy_cnt), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.iss_rec", 32'({bus.iss_qa, bus.iss_qb, bus.iss_two_q, bus.iss_src}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single grant: grant same cycle, issue one cycle later.
        #1;
        chk("s1.gnt", 32'(bus.req_gnt), 32'h01);
        sb.push_back(mk(12'h001, 12'h000, 1'b0, 3'd0));
        tick();
        bus.req_valid[0] = 1'b0;
        issue_chk("s1.iss");
        chk("s1.busy_cnt", 32'(busy_cnt), 32'd1);

        // Two slots on the same qubit: only one wins, the other waits for the release.
        bus.req_valid[1] = 1'b1;
        bus.req_qa[1]    = 12'h005;
        bus.req_valid[2] = 1'b1;
        bus.req_qa[2]    = 12'h005;
        #1;
        chk("s2.gnt1", 32'(bus.req_gnt), 32'h02);
        sb.push_back(mk(12'h005, 12'h000, 1'b0, 3'd1));
        tick();
        bus.req_valid[1] = 1'b0;
        issue_chk("s2.iss1");
        chk("s2.busy_cnt", 32'(busy_cnt), 32'd2);
        #1;
        chk("s2.locked", 32'(bus.req_gnt), 32'h00);
        tick();
        bus.cmp_valid = 1'b1;
        bus.cmp_qa    = 12'h005;
        #1;
        chk("s2.same_cycle", 32'(bus.req_gnt), 32'h00);
        tick();
        bus.cmp_valid = 1'b0;
        chk("s2.released", 32'(busy_cnt), 32'd1);
        #1;
        chk("s2.gnt2", 32'(bus.req_gnt), 32'h04);
        sb.push_back(mk(12'h005, 12'h000, 1'b0, 3'd2));
        tick();
        bus.req_valid[2] = 1'b0;
        issue_chk("s2.iss2");
        chk("s2.busy_cnt2", 32'(busy_cnt), 32'd2);
        bus.cmp_valid = 1'b1;
        bus.cmp_two_q = 1'b1;
        bus.cmp_qa    = 12'h001;
        bus.cmp_qb    = 12'h005;
        tick();
        bus.cmp_valid = 1'b0;
        bus.cmp_two_q = 1'b0;
        chk("s2.cleanup", 32'(busy_cnt), 32'd0);
        chk("s2.err", 32'(err), 32'd0);

        // Round-robin over disjoint qubits from a fresh pointer.
        pulse_reset("r1");
        for (int k = 0; k < 4; k++) begin
            bus.req_valid[k] = 1'b1;
            bus.req_qa[k]    = 12'h010 + 12'(k);
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("s3.gnt", 32'(bus.req_gnt), 32'(1) << k);
            sb.push_back(mk(12'h010 + 12'(k), 12'h000, 1'b0, 3'(k)));
            tick();
            bus.req_valid[k] = 1'b0;
            issue_chk("s3.iss");
        end
        chk("s3.busy_cnt", 32'(busy_cnt), 32'd4);

        // Back-pressure: record held, no grants; release grants in the same cycle.
        bus.req_valid[4] = 1'b1;
        bus.req_qa[4]    = 12'h020;
        bus.req_valid[5] = 1'b1;
        bus.req_qa[5]    = 12'h021;
        #1;
        chk("s4.gnt4", 32'(bus.req_gnt), 32'h10);
        sb.push_back(mk(12'h020, 12'h000, 1'b0, 3'd4));
        tick();
        bus.req_valid[4] = 1'b0;
        bus.iss_ready    = 1'b0;
        issue_chk("s4.hold0");
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("s4.nogrant", 32'(bus.req_gnt), 32'h00);
            tick();
            issue_chk("s4.hold");
        end
        bus.iss_ready = 1'b1;
        #1;
        chk("s4.gnt5", 32'(bus.req_gnt), 32'h20);
        sb.push_back(mk(12'h021, 12'h000, 1'b0, 3'd5));
        issue_chk("s4.accept");
        tick();
        bus.req_valid[5] = 1'b0;
        issue_chk("s4.iss5");
        chk("s4.busy_cnt", 32'(busy_cnt), 32'd6);

        // Two-qubit request naming one qubit twice, then a stray completion.
        bus.req_valid[6] = 1'b1;
        bus.req_two_q[6] = 1'b1;
        bus.req_qa[6]    = 12'hBBB;
        bus.req_qb[6]    = 12'hBBB;
        #1;
        chk("s5.gnt", 32'(bus.req_gnt), 32'h40);
        sb.push_back(mk(12'hBBB, 12'hBBB, 1'b1, 3'd6));
        tick();
        bus.req_valid[6] = 1'b0;
        bus.req_two_q[6] = 1'b0;
        issue_chk("s5.iss");
        chk("s5.busy_cnt", 32'(busy_cnt), 32'd7);
        bus.cmp_valid = 1'b1;
        bus.cmp_qa    = 12'hCCC;
        tick();
        bus.cmp_valid = 1'b0;
        chk("s5.err", 32'(err), 32'd1);
        chk("s5.stray_cnt", 32'(busy_cnt), 32'd7);
        bus.cmp_valid = 1'b1;
        bus.cmp_two_q = 1'b1;
        bus.cmp_qa    = 12'hBBB;
        bus.cmp_qb    = 12'hBBB;
        tick();
        bus.cmp_valid = 1'b0;
        bus.cmp_two_q = 1'b0;
        chk("s5.release", 32'(busy_cnt), 32'd6);
        chk("s5.err_sticky", 32'(err), 32'd1);

        // Grant and completion on different qubits in one cycle.
        bus.req_valid[7] = 1'b1;
        bus.req_qa[7]    = 12'h030;
        bus.cmp_valid    = 1'b1;
        bus.cmp_qa       = 12'h010;
        #1;
        chk("s6.gnt", 32'(bus.req_gnt), 32'h80);
        sb.push_back(mk(12'h030, 12'h000, 1'b0, 3'd7));
        tick();
        bus.req_valid[7] = 1'b0;
        bus.cmp_valid    = 1'b0;
        issue_chk("s6.iss");
        chk("s6.busy_cnt", 32'(busy_cnt), 32'd6);

        // qb of a single-qubit request is ignored even when it names a locked qubit.
        bus.req_valid[0] = 1'b1;
        bus.req_two_q[0] = 1'b1;
        bus.req_qa[0]    = 12'h040;
        bus.req_qb[0]    = 12'h041;
        bus.req_valid[1] = 1'b1;
        bus.req_two_q[1] = 1'b0;
        bus.req_qa[1]    = 12'h050;
        bus.req_qb[1]    = 12'h040;
        #1;
        chk("s7.gnt0", 32'(bus.req_gnt), 32'h01);
        sb.push_back(mk(12'h040, 12'h041, 1'b1, 3'd0));
        tick();
        bus.req_valid[0] = 1'b0;
        bus.req_two_q[0] = 1'b0;
        issue_chk("s7.iss0");
        chk("s7.busy_cnt2q", 32'(busy_cnt), 32'd8);
        #1;
        chk("s7.gnt1", 32'(bus.req_gnt), 32'h02);
        sb.push_back(mk(12'h050, 12'h000, 1'b0, 3'd1));
        tick();
        bus.req_valid[1] = 1'b0;
        issue_chk("s7.iss1");
        chk("s7.busy_cnt", 32'(busy_cnt), 32'd9);

        // Asynchronous reset in the middle of a held issue with three locks.
        pulse_reset("r2");
        bus.cmp_valid = 1'b1;
        bus.cmp_qa    = 12'h3FF;
        tick();
        bus.cmp_valid = 1'b0;
        chk("s8.err", 32'(err), 32'd1);
        for (int k = 0; k < 3; k++) begin
            bus.req_valid[k] = 1'b1;
            bus.req_qa[k]    = 12'h100 + 12'(k);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("s8.gnt", 32'(bus.req_gnt), 32'(1) << k);
            sb.push_back(mk(12'h100 + 12'(k), 12'h000, 1'b0, 3'(k)));
            tick();
            bus.req_valid[k] = 1'b0;
            if (k == 2) bus.iss_ready = 1'b0;
            issue_chk("s8.iss");
        end
        tick();
        issue_chk("s8.hold");
        chk("s8.busy_cnt", 32'(busy_cnt), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s8.rst_valid", 32'(bus.iss_valid), 32'd0);
        chk("s8.rst_busy", 32'(busy_cnt), 32'd0);
        chk("s8.rst_err", 32'(err), 32'd0);
        sb.delete();
        tick();
        rst_n         = 1'b1;
        bus.iss_ready = 1'b1;

        // After reset the pointer is back at 0 and old locks are gone.
        bus.req_valid[5] = 1'b1;
        bus.req_qa[5]    = 12'h100;
        bus.req_valid[0] = 1'b1;
        bus.req_qa[0]    = 12'h102;
        #1;
        chk("s9.gnt0", 32'(bus.req_gnt), 32'h01);
        sb.push_back(mk(12'h102, 12'h000, 1'b0, 3'd0));
        tick();
        bus.req_valid[0] = 1'b0;
        issue_chk("s9.iss0");
        #1;
        chk("s9.gnt5", 32'(bus.req_gnt), 32'h20);
        sb.push_back(mk(12'h100, 12'h000, 1'b0, 3'd5));
        tick();
        bus.req_valid[5] = 1'b0;
        issue_chk("s9.iss5");
        chk("s9.busy_cnt", 32'(busy_cnt), 32'd2);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qubit_issue_arbiter.md
QUBIT_ISSUE_ARBITER -- requirements
Module: qubit_issue_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8: number of instruction-slot requesters.
REQ-002 SHALL have parameter NUM_QUBITS, default 4096 (64 FPGAs x 64 qubits); QW = $clog2(NUM_QUBITS).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid, input, NUM_REQ bits, and req_gnt, output, NUM_REQ bits: one-hot grant, combinational, same cycle.
REQ-006 SHALL have ports req_qa and req_qb, input, NUM_REQ x QW: operand qubits; req_two_q, input, NUM_REQ bits: qb used.
REQ-007 SHALL have ports iss_valid, output, 1 bit, and iss_ready, input, 1 bit: downstream issue handshake.
REQ-008 SHALL have ports iss_qa and iss_qb, output, QW; iss_two_q, output, 1 bit; iss_src, output, $clog2(NUM_REQ): granted slot.
REQ-009 SHALL have ports cmp_valid, input, 1 bit; cmp_qa and cmp_qb, input, QW; cmp_two_q, input, 1 bit: completion/release.
REQ-010 SHALL have ports busy_cnt, output, QW+1 bits: locked-qubit count; err, output, 1 bit: sticky error.

Function
REQ-011 SHALL keep a NUM_QUBITS-bit busy scoreboard; a slot is eligible when req_valid=1 and qa, and qb if two_q, are not busy in registered state.
REQ-012 SHALL grant at most one eligible slot per cycle, round-robin; after grant to slot i, highest priority moves to i+1 mod NUM_REQ.
REQ-013 SHALL grant only when the output stage is empty or iss_ready=1 that cycle (two states: EMPTY, HOLD).
REQ-014 SHALL register the granted fields into iss_* at the grant edge; iss_valid rises one cycle after grant (latency 1).
REQ-015 SHALL hold iss_* stable while iss_valid=1 and iss_ready=0 (HOLD); handshake completes on iss_valid and iss_ready both 1.
REQ-016 SHALL set busy bits of granted qubits at the grant edge; they stay set until matching completion.
REQ-017 SHALL clear busy bits named by cmp_valid at the rising edge; the freed qubit becomes eligible the following cycle, never the same cycle.
REQ-018 SHALL treat two_q with qa==qb as a single-qubit lock (one bit, busy_cnt +1).
REQ-019 SHALL, on completion of a non-busy qubit, ignore that bit and set err; err stays set until reset.
REQ-020 SHALL update busy_cnt as +set bits -cleared bits in the same edge; simultaneous grant and completion on different qubits are both applied.
REQ-021 SHALL ignore qb fields when the corresponding two_q bit is 0.

Reset
REQ-022 SHALL, on rst_n=0, asynchronously clear scoreboard, busy_cnt, err, iss_valid, iss_* fields, req_gnt, and set the round-robin pointer to 0.
REQ-023 SHALL drop in-flight issue and all locks on reset mid-operation; nothing is replayed.

Configuration
REQ-024 SHALL, with QIA_STATS_EN defined, add output stall_cnt, 32 bits: increments each cycle any req_valid=1 and no grant, saturates at all-ones, resets to 0.
REQ-025 SHALL, without QIA_STATS_EN, have no stall_cnt port and no counter logic.

Structure
REQ-026 SHALL take QW computation, the issue-record typedef {qa, qb, two_q, src} and the EMPTY/HOLD state enum from package qsched_pkg.
REQ-027 SHALL instantiate sub-module rr_arbiter (parameter N; inputs req, ptr; output one-hot gnt) for the priority rotation.

Verification
REQ-028 SHALL cover: reset, slot 0 req qa=0x001 single -> req_gnt=0x01 cycle N, iss_valid=1 iss_qa=0x001 cycle N+1, busy_cnt=1.
REQ-029 SHALL cover: slots 1 and 2 both request qa=0x005 -> only slot 1 granted; slot 2 granted the cycle after cmp_valid qa=0x005.
REQ-030 SHALL cover: slots 0..3 valid, disjoint qubits, iss_ready=1 -> grants 0,1,2,3 on consecutive cycles, busy_cnt=4.
REQ-031 SHALL cover: iss_ready=0 for 5 cycles -> iss_* unchanged, no further grants; iss_ready=1 -> next grant same cycle.
REQ-032 SHALL cover: two_q qa=qb=0xBBB -> busy_cnt=1; cmp_valid on idle qubit 0xCCC -> err=1 and busy_cnt unchanged.
REQ-033 SHALL cover: rst_n low mid-HOLD with busy_cnt=3 -> iss_valid=0, busy_cnt=0, err=0 immediately, without a clock edge.
